// File: rtl/fbrc_count_ctrl_pkg.sv
// Shared definitions for the board counter run-control sequencer:
// FSM state encodings and the default prescaler / counter sizing.
package fbrc_count_ctrl_pkg;

    // Run-control states; the numeric values are visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } fbrc_state_e;

    // 25 MHz board clock divided down to a 1 Hz count tick
    localparam int unsigned   DEF_PRESCALE_W   = 25;
    localparam logic [24:0]   DEF_PRESCALE_MAX = 25'd24999999;

    // 4-bit counter that one-shot mode stops at full scale
    localparam int unsigned   DEF_CNT_W        = 4;
    localparam logic [3:0]    DEF_LIMIT        = 4'd15;

endpackage

// File: rtl/fbrc_count_ctrl_btn_edge_pulse.sv
// Button conditioning: two-flop synchroniser followed by an edge register.
// Produces a single-cycle pulse on each rising edge of the raw button, so a
// held button yields exactly one pulse. Runs on the falling clock edge like
// the rest of the counter logic.
module btn_edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_p
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the raw level through the synchroniser and into the edge register
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Falling-edge flops with synchronous clear
    always_ff @(negedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign btn_p = sync2_q & ~prev_q;

endmodule

// File: rtl/fbrc_count_ctrl.sv
// Run-control sequencer for the 4-bit board counter. Converts the start,
// stop and step buttons into pulses, paces counting with a prescaler and
// drives the counter's enable/clear inputs. All state changes on the
// falling clock edge, the same edge the counter flops use.
module fbrc_count_ctrl
    import fbrc_count_ctrl_pkg::*;
#(
    parameter int unsigned            PRESCALE_W   = DEF_PRESCALE_W,
    parameter logic [PRESCALE_W-1:0]  PRESCALE_MAX = DEF_PRESCALE_MAX,
    parameter int unsigned            CNT_W        = DEF_CNT_W,
    parameter logic [CNT_W-1:0]       LIMIT        = DEF_LIMIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             step_btn,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    logic start_p, stop_p, step_p;

    fbrc_state_e           state_q,   state_d;
    logic [PRESCALE_W-1:0] pre_q,     pre_d;
    logic                  cnt_en_q,  cnt_en_d;
    logic                  cnt_clr_q, cnt_clr_d;

    logic tick;
    logic at_limit;

    btn_edge_pulse u_start (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (start_btn),
        .btn_p   (start_p)
    );

    btn_edge_pulse u_stop (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (stop_btn),
        .btn_p   (stop_p)
    );

    btn_edge_pulse u_step (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (step_btn),
        .btn_p   (step_p)
    );

    assign tick     = (pre_q == PRESCALE_MAX);
    assign at_limit = oneshot && (cnt_q == LIMIT);

    // Next state, prescaler and counter controls; stop outranks start, start outranks step
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!stop_p && start_p) begin
                    cnt_clr_d = 1'b1;
                    pre_d     = '0;
                    state_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                if (stop_p) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    pre_d = '0;
                    if (at_limit) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PRESCALE_W'(1);
                end
            end

            ST_PAUSE: begin
                if (stop_p) begin
                    cnt_clr_d = 1'b1;
                    pre_d     = '0;
                    state_d   = ST_IDLE;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end else if (step_p) begin
                    if (at_limit) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (stop_p) begin
                    cnt_clr_d = 1'b1;
                    pre_d     = '0;
                    state_d   = ST_IDLE;
                end else if (start_p) begin
                    cnt_clr_d = 1'b1;
                    pre_d     = '0;
                    state_d   = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
            end
        endcase
    end

    // Falling-edge state register; reset aborts any run immediately
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign cnt_clr = cnt_clr_q;
    assign state   = state_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_fbrc_count_ctrl.sv
// Bench for the run-control sequencer. A behavioural model tracks the
// expected outputs each falling edge and queues them; a monitor on the
// rising edge pops and compares. Directed scenarios are followed by a
// randomized button phase.
module tb_fbrc_count_ctrl;

    localparam int          PMAX   = 3;
    localparam logic [3:0]  LIM    = 4'd5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       start_btn = 1'b0;
    logic       stop_btn  = 1'b0;
    logic       step_btn  = 1'b0;
    logic       oneshot   = 1'b0;
    logic [3:0] cnt_q;
    logic       cnt_en;
    logic       cnt_clr;
    logic [1:0] state;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int en_seen = 0;

    logic [5:0] exp_q[$];

    // Model state
    int       m_mode    = M_IDLE;
    int       m_elapsed = 0;
    bit       m_en      = 1'b0;
    bit       m_clr     = 1'b0;
    bit [2:0] h_start   = '0;
    bit [2:0] h_stop    = '0;
    bit [2:0] h_step    = '0;

    fbrc_count_ctrl #(
        .PRESCALE_W   (2),
        .PRESCALE_MAX (2'd3),
        .CNT_W        (4),
        .LIMIT        (4'd5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .step_btn  (step_btn),
        .oneshot   (oneshot),
        .cnt_q     (cnt_q),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .state     (state),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Board counter the sequencer drives; same falling edge
    always @(negedge clk) begin
        if (reset)        cnt_q <= 4'd0;
        else if (cnt_clr) cnt_q <= 4'd0;
        else if (cnt_en)  cnt_q <= cnt_q + 4'd1;
    end

    // Reference model: a button counts as pressed two edges after the edge
    // that first sees it high, provided the edge before that saw it low
    always @(negedge clk) begin
        bit ps, pt, pp, lim;
        logic [5:0] e;
        ps  = h_start[1] & ~h_start[2];
        pt  = h_stop[1]  & ~h_stop[2];
        pp  = h_step[1]  & ~h_step[2];
        lim = oneshot && (cnt_q == LIM);
        m_en  = 1'b0;
        m_clr = 1'b0;
        if (reset) begin
            m_mode    = M_IDLE;
            m_elapsed = 0;
            h_start   = '0;
            h_stop    = '0;
            h_step    = '0;
        end else begin
            if (m_mode == M_IDLE) begin
                if (ps && !pt) begin
                    m_clr = 1'b1; m_elapsed = 0; m_mode = M_RUN;
                end
            end else if (m_mode == M_RUN) begin
                if (pt) begin
                    m_mode = M_PAUSE;
                end else if (m_elapsed == PMAX) begin
                    m_elapsed = 0;
                    if (lim) m_mode = M_DONE;
                    else     m_en   = 1'b1;
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end else if (m_mode == M_PAUSE) begin
                if (pt) begin
                    m_clr = 1'b1; m_elapsed = 0; m_mode = M_IDLE;
                end else if (ps) begin
                    m_mode = M_RUN;
                end else if (pp) begin
                    if (lim) m_mode = M_DONE;
                    else     m_en   = 1'b1;
                end
            end else begin
                if (pt) begin
                    m_clr = 1'b1; m_elapsed = 0; m_mode = M_IDLE;
                end else if (ps) begin
                    m_clr = 1'b1; m_elapsed = 0; m_mode = M_RUN;
                end
            end
            h_start = {h_start[1:0], start_btn};
            h_stop  = {h_stop[1:0],  stop_btn};
            h_step  = {h_step[1:0],  step_btn};
        end
        e = {2'(m_mode), m_en, m_clr, (m_mode == M_RUN), (m_mode == M_DONE)};
        exp_q.push_back(e);
    end

    // Monitor: compare the DUT against the oldest queued expectation
    always @(posedge clk) begin
        logic [5:0] ex;
        logic [5:0] act;
        if (cnt_en === 1'b1) en_seen <= en_seen + 1;
        if (exp_q.size() > 0) begin
            ex  = exp_q.pop_front();
            act = {state, cnt_en, cnt_clr, busy, done};
            checks++;
            if (act !== ex) begin
                errors++;
                $display("[TB] FAIL outputs t=%0t actual state=%0d en=%b clr=%b busy=%b done=%b required state=%0d en=%b clr=%b busy=%b done=%b",
                         $time, act[5:4], act[3], act[2], act[1], act[0],
                         ex[5:4], ex[3], ex[2], ex[1], ex[0]);
            end
            checks++;
            if ((cnt_en & cnt_clr) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL en_clr_exclusive t=%0t actual en=%b clr=%b required not both", $time, cnt_en, cnt_clr);
            end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    // Drive one or more buttons high for hold cycles, then release and settle
    task automatic apply_stimulus(input bit st, input bit sp, input bit sk, input int hold);
        @(posedge clk);
        start_btn = st;
        stop_btn  = sp;
        step_btn  = sk;
        wait_cycles(hold);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        step_btn  = 1'b0;
        wait_cycles(5);
    endtask

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    initial begin
        int base;

        // Power-up reset
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        check_output("reset_state", state, 0);

        // Reset held two cycles mid-run
        apply_stimulus(1'b1, 1'b0, 1'b0, 2);
        wait_cycles(6);
        check_output("run_before_reset", state, 1);
        @(posedge clk); reset = 1'b1;
        wait_cycles(2);
        reset = 1'b0;
        @(posedge clk);
        check_output("reset_mid_run_state", state, 0);
        check_output("reset_mid_run_busy", busy, 0);

        // Free-running count, long enough to wrap the counter
        oneshot = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 2);
        wait_cycles(70);
        check_output("freerun_busy", busy, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("freerun_paused", state, 2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("back_to_idle", state, 0);

        // One-shot: five enables then DONE
        oneshot = 1'b1;
        base = en_seen;
        apply_stimulus(1'b1, 1'b0, 1'b0, 2);
        wait_cycles(40);
        check_output("oneshot_en_count", en_seen - base, 5);
        check_output("oneshot_done", done, 1);
        check_output("oneshot_state", state, 3);

        // Stop / resume with held prescaler
        oneshot = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        wait_cycles(2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1);
        check_output("pause_state", state, 2);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        wait_cycles(10);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("pause_again", state, 2);

        // Stepping while paused
        base = en_seen;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 2);
        check_output("step_count", en_seen - base, 3);
        base = en_seen;
        apply_stimulus(1'b0, 1'b0, 1'b1, 50);
        check_output("step_held", en_seen - base, 1);

        // Coincident start and stop
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("idle_before_both", state, 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 2);
        check_output("both_in_idle", state, 0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 2);
        wait_cycles(3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 2);
        check_output("both_in_run", state, 2);

        // Randomized buttons, mode and occasional reset
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            if ($urandom_range(0, 7) == 0)   start_btn = ~start_btn;
            if ($urandom_range(0, 11) == 0)  stop_btn  = ~stop_btn;
            if ($urandom_range(0, 5) == 0)   step_btn  = ~step_btn;
            if ($urandom_range(0, 99) == 0)  oneshot   = ~oneshot;
            reset = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk);
        reset = 1'b0;
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        step_btn  = 1'b0;
        wait_cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
